if_fetch_ctrl: RTL and testbench
================================

// Module: if_fetch_ctrl
// PURPOSE
//  Instruction-fetch sequencer. Owns the program counter and drives a single-outstanding
//  req/ack instruction-memory port. Presents fetched instructions to the IF/ID boundary
//  and applies pipeline stall, branch redirect, exception flush and halt.
// PARAMETERS
//  RESET_PC   32'h00000000  first fetch address after reset
//  ADDR_W     32            address / PC width
//  INST_W     32            instruction width
// PORTS
//  clk            in   1       clock; all state updates on the rising edge
//  rst            in   1       asynchronous, active-low reset (rst==0 resets)
//  stall          in   1       IF/ID must hold its current contents
//  halt           in   1       stop issuing new fetches
//  flush          in   1       exception flush; highest priority
//  flush_pc       in   ADDR_W  flush target (handler vector)
//  branch_flag    in   1       taken branch/jump from decode
//  branch_target  in   ADDR_W  branch destination
//  imem_req       out  1       fetch request; registered
//  imem_addr      out  ADDR_W  fetch address; registered; stable while imem_req && !imem_ack
//  imem_ack       in   1       request completes this cycle; imem_rdata valid
//  imem_rdata     in   INST_W  fetched instruction
//  if_pc          out  ADDR_W  PC of if_inst
//  if_inst        out  INST_W  instruction to decode
//  if_valid       out  1       if_pc/if_inst valid
// BEHAVIOUR
//  Reset (async, rst==0): state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC,
//   if_pc=0, if_inst=0, if_valid=0, skid empty, discard=0.
//  States: IDLE, REQ, HOLD, HALT.
//  - IDLE: one cycle after reset release, then REQ with imem_req=1, imem_addr=pc.
//  - REQ: wait for imem_ack. On an accepted ack: pc<=pc+4; if !halt, then next cycle
//    imem_req=1, imem_addr=pc+4 (back-to-back; 1 instr/cycle with zero-wait memory).
//    If halt, imem_req<=0 and go to HALT.
//  - On accepted ack with stall=0: next cycle if_inst=imem_rdata, if_pc=fetch addr,
//    if_valid=1. With stall=1: data goes to the skid register, imem_req<=0, go to HOLD.
//  - HOLD: no request. When stall=0: skid moves to if_*, if_valid=1, then REQ
//    (or HALT if halt=1).
//  - HALT: imem_req=0, pc holds. Go to REQ at pc when halt=0.
//  - Cycle with stall=0 and no new data for if_*: if_valid<=0 (bubble).
//    stall=1: if_* hold their values.
//  Redirect (flush over branch; branch_flag ignored while stall=1):
//  - pc<=target with bits[1:0] forced to 0. if_valid<=0. Skid emptied. HOLD/HALT go to REQ.
//    flush overrides stall and halt for this one redirect.
//  - Redirect in REQ without ack: request is never withdrawn; set discard=1 and keep the
//    old imem_addr. The next ack's data is dropped, discard is cleared, and the next
//    cycle requests the new pc.
//  - Redirect in the same cycle as an ack: that data is dropped, no discard. Next cycle
//    requests the target.
//  - Ack while discard=1: data dropped, pc not incremented.
//  Arithmetic: pc+4 is modulo 2^ADDR_W; 32'hFFFFFFFC wraps to 32'h00000000.
//  Reset mid-fetch: everything returns to reset values immediately. An ack arriving
//   during reset is ignored.
// TESTING
//  1 Reset release, ack every cycle -> imem_addr 0,4,8,...; if_valid from cycle 3;
//    if_pc 0,4,8 with matching if_inst.
//  2 Ack at addr 8 with stall=1 for 3 cycles -> imem_req low, if_* hold addr 4;
//    stall drops -> if_pc=8, then req addr 12.
//  3 branch_flag (target 0x103) during pending fetch of 0x20, ack 2 cycles later ->
//    0x20 data dropped; next req addr 0x100; first if_pc=0x100.
//  4 flush (flush_pc 0x180) with stall=1, same cycle as ack -> if_valid=0 next cycle;
//    req 0x180; no instruction from the old stream appears.
//  5 RESET_PC=32'hFFFFFFF8, continuous ack -> addrs FFFFFFF8, FFFFFFFC, 00000000.
//  6 halt=1 mid-REQ -> pending fetch completes and is delivered, then imem_req=0;
//    halt=0 -> fetch resumes at next sequential pc.

Source files
------------

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives a single-outstanding
// req/ack imem port and feeds the IF/ID boundary.
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter int          ADDR_W   = 32,
  parameter int          INST_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              halt,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0] if_pc,
  output logic [INST_W-1:0] if_inst,
  output logic              if_valid
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD,
    HALT
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_t;

  localparam logic [ADDR_W-1:0] RST_PC =
    RESET_PC[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] ALIGN =
    {{(ADDR_W-2){1'b1}}, 2'b00};
  localparam logic [ADDR_W-1:0] STEP =
    ADDR_W'(4);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              req_q, req_d;
  fetch_t            if_q, if_d;
  logic              ifv_q, ifv_d;
  fetch_t            sk_q, sk_d;
  logic              skv_q, skv_d;
  logic              disc_q, disc_d;

  logic              redir;
  logic              take;
  logic [ADDR_W-1:0] raw_tgt;
  logic [ADDR_W-1:0] tgt;
  logic [ADDR_W-1:0] pc_inc;

  assign redir   = flush | (branch_flag & ~stall);
  assign raw_tgt = flush ? flush_pc : branch_target;
  assign tgt     = raw_tgt & ALIGN;
  assign take    = (state_q == REQ) & req_q & imem_ack;
  assign pc_inc  = pc_q + STEP;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    req_d   = req_q;
    if_d    = if_q;
    ifv_d   = stall ? ifv_q : 1'b0;
    sk_d    = sk_q;
    skv_d   = skv_q;
    disc_d  = disc_q;

    unique case (state_q)
      IDLE: begin
        if (halt) begin
          state_d = HALT;
        end else begin
          state_d = REQ;
          req_d   = 1'b1;
          addr_d  = pc_q;
        end
      end
      REQ: begin
        if (take && disc_q) begin
          // stale response from before a redirect
          disc_d = 1'b0;
          if (halt) begin
            req_d   = 1'b0;
            state_d = HALT;
          end else begin
            addr_d = pc_q;
          end
        end else if (take) begin
          pc_d = pc_inc;
          if (stall) begin
            sk_d.pc   = addr_q;
            sk_d.inst = imem_rdata;
            skv_d     = 1'b1;
            req_d     = 1'b0;
            state_d   = HOLD;
          end else begin
            if_d.pc   = addr_q;
            if_d.inst = imem_rdata;
            ifv_d     = 1'b1;
            if (halt) begin
              req_d   = 1'b0;
              state_d = HALT;
            end else begin
              addr_d = pc_inc;
            end
          end
        end
      end
      HOLD: begin
        if (!stall) begin
          if_d  = sk_q;
          ifv_d = skv_q;
          skv_d = 1'b0;
          if (halt) begin
            state_d = HALT;
          end else begin
            state_d = REQ;
            req_d   = 1'b1;
            addr_d  = pc_q;
          end
        end
      end
      HALT: begin
        if (!halt) begin
          state_d = REQ;
          req_d   = 1'b1;
          addr_d  = pc_q;
        end
      end
      default: state_d = IDLE;
    endcase

    // a live request cannot be withdrawn, so mark its response stale
    if (redir) begin
      pc_d    = tgt;
      ifv_d   = 1'b0;
      skv_d   = 1'b0;
      state_d = REQ;
      req_d   = 1'b1;
      if ((state_q == REQ) && req_q && !imem_ack) begin
        disc_d = 1'b1;
        addr_d = addr_q;
      end else begin
        disc_d = 1'b0;
        addr_d = tgt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pc_q    <= RST_PC;
      addr_q  <= RST_PC;
      req_q   <= 1'b0;
      if_q    <= '0;
      ifv_q   <= 1'b0;
      sk_q    <= '0;
      skv_q   <= 1'b0;
      disc_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      if_q    <= if_d;
      ifv_q   <= ifv_d;
      sk_q    <= sk_d;
      skv_q   <= skv_d;
      disc_q  <= disc_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign if_pc     = if_q.pc;
  assign if_inst   = if_q.inst;
  assign if_valid  = ifv_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Scoreboard bench for if_fetch_ctrl: directed stall, redirect,
// flush, halt, wrap and reset scenarios.
module tb_if_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        halt;
  logic        flush;
  logic [31:0] flush_pc;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;

  logic        req1;
  logic [31:0] addr1;
  logic        ack1;
  logic [31:0] rdata1;
  logic [31:0] pc1;
  logic [31:0] inst1;
  logic        valid1;
  logic        zero1;
  logic [31:0] zero32;

  int total = 0;
  int bad   = 0;

  logic [31:0] aq[$];
  logic [31:0] iq[$];

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a << 8) ^ 32'hCAFE_0013;
  endfunction

  assign imem_rdata = mem(imem_addr);
  assign rdata1     = mem(addr1);

  if_fetch_ctrl u_dut (
    .clk(clk), .rst(rst), .stall(stall), .halt(halt),
    .flush(flush), .flush_pc(flush_pc),
    .branch_flag(branch_flag), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .if_pc(if_pc), .if_inst(if_inst), .if_valid(if_valid)
  );

  if_fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .rst(rst), .stall(zero1), .halt(zero1),
    .flush(zero1), .flush_pc(zero32),
    .branch_flag(zero1), .branch_target(zero32),
    .imem_req(req1), .imem_addr(addr1),
    .imem_ack(ack1), .imem_rdata(rdata1),
    .if_pc(pc1), .if_inst(inst1), .if_valid(valid1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (imem_req && imem_ack) begin
        if (aq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL addr_extra: got %h want none", imem_addr);
        end else begin
          chk("imem_addr", imem_addr, aq.pop_front());
        end
      end
      if (if_valid && !stall && !flush) begin
        if (iq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL inst_extra: got pc %h want none", if_pc);
        end else begin
          logic [31:0] e;
          e = iq.pop_front();
          chk("if_pc", if_pc, e);
          chk("if_inst", if_inst, mem(e));
        end
      end
    end
  end

  initial begin
    logic [31:0] av[14];
    logic [31:0] iv[11];
    av = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14,
           32'h18, 32'h1C, 32'h20, 32'h100, 32'h104,
           32'h108, 32'h180, 32'h184};
    iv = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14,
           32'h18, 32'h1C, 32'h100, 32'h180, 32'h184};
    rst = 1'b1;
    stall = 1'b0;
    halt = 1'b0;
    flush = 1'b0;
    flush_pc = '0;
    branch_flag = 1'b0;
    branch_target = '0;
    zero1 = 1'b0;
    zero32 = '0;
    imem_ack = 1'b1;
    ack1 = 1'b1;
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_inst", if_inst, 32'd0);
    chk("rst_wrap_addr", addr1, 32'hFFFF_FFF8);
    foreach (av[i]) aq.push_back(av[i]);
    foreach (iv[i]) iq.push_back(iv[i]);
    rst = 1'b1;
    // sequential fetch, wrap instance alongside
    tick();
    chk("e1_req", {31'd0, imem_req}, 32'd1);
    chk("e1_addr", imem_addr, 32'h0);
    chk("wrap0", addr1, 32'hFFFF_FFF8);
    tick();
    chk("wrap1", addr1, 32'hFFFF_FFFC);
    tick();
    chk("wrap2", addr1, 32'h0000_0000);
    chk("e3_pc", if_pc, 32'h4);
    stall = 1'b1;
    // stall while addr 8 is acked
    tick();
    chk("hold_req", {31'd0, imem_req}, 32'd0);
    chk("hold_pc", if_pc, 32'h4);
    tick();
    chk("hold_pc2", if_pc, 32'h4);
    chk("hold_valid", {31'd0, if_valid}, 32'd1);
    tick();
    stall = 1'b0;
    tick();
    chk("skid_pc", if_pc, 32'h8);
    chk("resume_addr", imem_addr, 32'hC);
    repeat (4) tick();
    // branch during pending fetch of 0x20
    tick();
    chk("pend_addr", imem_addr, 32'h20);
    chk("pre_br_pc", if_pc, 32'h1C);
    imem_ack = 1'b0;
    branch_flag = 1'b1;
    branch_target = 32'h103;
    tick();
    branch_flag = 1'b0;
    chk("disc_addr", imem_addr, 32'h20);
    chk("disc_req", {31'd0, imem_req}, 32'd1);
    chk("br_valid", {31'd0, if_valid}, 32'd0);
    tick();
    imem_ack = 1'b1;
    tick();
    chk("tgt_addr", imem_addr, 32'h100);
    chk("drop_valid", {31'd0, if_valid}, 32'd0);
    tick();
    chk("tgt_pc", if_pc, 32'h100);
    chk("tgt_valid", {31'd0, if_valid}, 32'd1);
    // flush with stall, coincident with ack of 0x108
    tick();
    chk("pre_fl_pc", if_pc, 32'h104);
    stall = 1'b1;
    flush = 1'b1;
    flush_pc = 32'h180;
    tick();
    flush = 1'b0;
    stall = 1'b0;
    chk("fl_valid", {31'd0, if_valid}, 32'd0);
    chk("fl_addr", imem_addr, 32'h180);
    // halt while 0x180 is outstanding
    halt = 1'b1;
    imem_ack = 1'b0;
    tick();
    imem_ack = 1'b1;
    tick();
    chk("halt_req", {31'd0, imem_req}, 32'd0);
    chk("halt_pc", if_pc, 32'h180);
    chk("halt_valid", {31'd0, if_valid}, 32'd1);
    tick();
    chk("halt_req2", {31'd0, imem_req}, 32'd0);
    chk("halt_bubble", {31'd0, if_valid}, 32'd0);
    halt = 1'b0;
    tick();
    chk("unhalt_req", {31'd0, imem_req}, 32'd1);
    chk("unhalt_addr", imem_addr, 32'h184);
    tick();
    imem_ack = 1'b0;
    chk("last_pc", if_pc, 32'h184);
    tick();
    chk("pend2_addr", imem_addr, 32'h188);
    // asynchronous reset mid-fetch
    #2 rst = 1'b0;
    #1;
    chk("arst_req", {31'd0, imem_req}, 32'd0);
    chk("arst_addr", imem_addr, 32'd0);
    chk("arst_valid", {31'd0, if_valid}, 32'd0);
    tick();
    chk("aq_left", aq.size(), 32'd0);
    chk("iq_left", iq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
